// File: rtl/rf_pkg.sv
// Shared definitions for the rf_mp multi-port register file: default sizes and FSM state type.
package rf_pkg;

    localparam int RF_DW_DEF    = 32;
    localparam int RF_DEPTH_DEF = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight results; a claim in the same cycle as a retiring write wins.
module rf_scoreboard #(
    parameter  int DEPTH  = 32,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   init_en,
    input  logic [AW-1:0]          init_sel,
    input  logic [NUM_WR-1:0]      clr_en,
    input  logic [NUM_WR*AW-1:0]   clr_sel,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_sel,
    input  logic [NUM_RD*AW-1:0]   rd_sel,
    output logic [NUM_RD-1:0]      rd_busy
);

    logic [DEPTH-1:0] busy;

    // Clears are applied first so a same-cycle claim to the same entry overrides them.
    always_ff @(posedge clk) begin
        if (init_en) begin
            busy[init_sel] <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (clr_en[w]) begin
                    busy[clr_sel[w*AW +: AW]] <= 1'b0;
                end
            end
            if (claim_en) begin
                busy[claim_sel] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy[p] = busy[rd_sel[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port register file with busy scoreboard and sequential init clear.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rf_mp
    import rf_pkg::*;
#(
    parameter  int DW       = RF_DW_DEF,
    parameter  int DEPTH    = RF_DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [NUM_RD*AW-1:0]  rd_sel,
    output logic [NUM_RD*DW-1:0]  rd_data,
    output logic [NUM_RD-1:0]     rd_busy,
    input  logic [NUM_WR-1:0]     wr_en,
    input  logic [NUM_WR*AW-1:0]  wr_sel,
    input  logic [NUM_WR*DW-1:0]  wr_data,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_sel
);

    rf_state_e          state;
    rf_state_e          state_nxt;
    logic [AW-1:0]      cnt;
    logic               init_en;
    logic               run;
    logic [NUM_WR-1:0]  wr_ok;
    logic               claim_ok;
    logic [NUM_RD-1:0]  sb_busy;
    logic [DW-1:0]      mem [DEPTH];

    logic [AW-1:0]      rsel;
    logic [DW-1:0]      rdat;
    logic               rbsy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == {AW{1'b1}}) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        ready   = (state == RUN);
        run     = (state == RUN);
        init_en = (state == INIT);
    end

    // Writes and claims to register 0 are dropped when it is hardwired to zero.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wr_en[w] && run &&
                       !((ZERO_REG != 0) && (wr_sel[w*AW +: AW] == '0));
        end
        claim_ok = claim_en && run && !((ZERO_REG != 0) && (claim_sel == '0));
    end

    // Ascending port order lets the highest-index port win a same-register conflict.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    mem[wr_sel[w*AW +: AW]] <= wr_data[w*DW +: DW];
                end
            end
        end
    end

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk       (clk),
        .init_en   (init_en),
        .init_sel  (cnt),
        .clr_en    (wr_ok),
        .clr_sel   (wr_sel),
        .claim_en  (claim_ok),
        .claim_sel (claim_sel),
        .rd_sel    (rd_sel),
        .rd_busy   (sb_busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rsel    = '0;
        rdat    = '0;
        rbsy    = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            rsel = rd_sel[p*AW +: AW];
            rdat = mem[rsel];
            rbsy = sb_busy[p];
`ifdef RF_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wr_sel[w*AW +: AW] == rsel)) begin
                    rdat = wr_data[w*DW +: DW];
                    rbsy = claim_ok && (claim_sel == rsel);
                end
            end
`endif
            if ((ZERO_REG != 0) && (rsel == '0)) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            if (!ready) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            rd_data[p*DW +: DW] = rdat;
            rd_busy[p]          = rbsy;
        end
    end

endmodule

// File: tb/tb_rf_mp.sv
// Directed testbench for rf_mp (2 read ports, 2 write ports, 32 x 32-bit, ZERO_REG=1).
module tb_rf_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ready;
    logic [2*AW-1:0]   rd_sel = '0;
    logic [2*DW-1:0]   rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en = '0;
    logic [2*AW-1:0]   wr_sel = '0;
    logic [2*DW-1:0]   wr_data = '0;
    logic              claim_en = 1'b0;
    logic [AW-1:0]     claim_sel = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_mp #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .claim_en  (claim_en),
        .claim_sel (claim_sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = '0;
        claim_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_sel = {5'd5, 5'd0};
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            if (ready !== 1'b0 || rd_data !== 64'h0) begin
                $display("FAIL init_hold cycle %0d: ready=%b data=%h required ready=0 data=0", i, ready, rd_data);
                errors++;
            end
            checks++;
            step();
        end
        if (ready !== 1'b1) begin
            $display("FAIL init_ready: ready=%b required 1", ready);
            errors++;
        end
        checks++;
        for (int r = 0; r < DEPTH; r += 2) begin
            rd_sel = {AW'(r + 1), AW'(r)};
            #1;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                $display("FAIL init_clear r%0d: data=%h busy=%b required 0/00", r, rd_data, rd_busy);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_write_read();
        wr_en   = 2'b01;
        wr_sel  = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEADBEEF};
        rd_sel  = {5'd5, 5'd5};
        #1;
        if (rd_data !== (BYP ? {2{32'hDEADBEEF}} : 64'h0)) begin
            $display("FAIL wr_same_cycle: data=%h required %h", rd_data,
                     (BYP ? {2{32'hDEADBEEF}} : 64'h0));
            errors++;
        end
        checks++;
        step();
        idle_inputs();
        #1;
        if (rd_data !== {2{32'hDEADBEEF}}) begin
            $display("FAIL wr_next_cycle: data=%h required %h", rd_data, {2{32'hDEADBEEF}});
            errors++;
        end
        checks++;
    endtask

    task automatic test_dual_write();
        wr_en   = 2'b11;
        wr_sel  = {5'd7, 5'd7};
        wr_data = {32'h2222, 32'h1111};
        step();
        idle_inputs();
        rd_sel = {5'd7, 5'd7};
        #1;
        if (rd_data !== {2{32'h2222}}) begin
            $display("FAIL dual_write_conflict: data=%h required %h", rd_data, {2{32'h2222}});
            errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        wr_en   = 2'b11;
        wr_sel  = {5'd4, 5'd3};
        wr_data = {32'hBBBB0004, 32'hAAAA0003};
        step();
        wr_en   = 2'b01;
        wr_sel  = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hCCCC0003};
        step();
        idle_inputs();
        rd_sel = {5'd3, 5'd4};
        #1;
        if (rd_data !== {32'hCCCC0003, 32'hBBBB0004}) begin
            $display("FAIL back_to_back: data=%h required %h", rd_data, {32'hCCCC0003, 32'hBBBB0004});
            errors++;
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        rd_sel    = {5'd9, 5'd9};
        claim_en  = 1'b1;
        claim_sel = 5'd9;
        #1;
        if (rd_busy !== 2'b00) begin
            $display("FAIL claim_same_cycle: busy=%b required 00", rd_busy);
            errors++;
        end
        checks++;
        step();
        idle_inputs();
        #1;
        if (rd_busy !== 2'b11) begin
            $display("FAIL claim_busy: busy=%b required 11", rd_busy);
            errors++;
        end
        checks++;
        wr_en   = 2'b10;
        wr_sel  = {5'd9, 5'd0};
        wr_data = {32'h42, 32'h0};
        #1;
        if (rd_busy !== (BYP ? 2'b00 : 2'b11) || rd_data !== (BYP ? {2{32'h42}} : 64'h0)) begin
            $display("FAIL retire_same_cycle: busy=%b data=%h required %b %h", rd_busy, rd_data,
                     (BYP ? 2'b00 : 2'b11), (BYP ? {2{32'h42}} : 64'h0));
            errors++;
        end
        checks++;
        step();
        idle_inputs();
        #1;
        if (rd_busy !== 2'b00 || rd_data !== {2{32'h42}}) begin
            $display("FAIL retire_next: busy=%b data=%h required 00 %h", rd_busy, rd_data, {2{32'h42}});
            errors++;
        end
        checks++;
        claim_en  = 1'b1;
        claim_sel = 5'd9;
        wr_en     = 2'b01;
        wr_sel    = {5'd0, 5'd9};
        wr_data   = {32'h0, 32'h77};
        #1;
        if (rd_busy !== (BYP ? 2'b11 : 2'b00) || rd_data !== (BYP ? {2{32'h77}} : {2{32'h42}})) begin
            $display("FAIL claim_write_same_cycle: busy=%b data=%h required %b %h", rd_busy, rd_data,
                     (BYP ? 2'b11 : 2'b00), (BYP ? {2{32'h77}} : {2{32'h42}}));
            errors++;
        end
        checks++;
        step();
        idle_inputs();
        #1;
        if (rd_busy !== 2'b11 || rd_data !== {2{32'h77}}) begin
            $display("FAIL claim_over_write: busy=%b data=%h required 11 %h", rd_busy, rd_data, {2{32'h77}});
            errors++;
        end
        checks++;
    endtask

    task automatic test_zero_reg();
        wr_en     = 2'b11;
        wr_sel    = {5'd0, 5'd0};
        wr_data   = {32'hFFFF, 32'hFFFF};
        claim_en  = 1'b1;
        claim_sel = 5'd0;
        rd_sel    = {5'd0, 5'd0};
        #1;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            $display("FAIL zero_same_cycle: data=%h busy=%b required 0 00", rd_data, rd_busy);
            errors++;
        end
        checks++;
        step();
        idle_inputs();
        #1;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            $display("FAIL zero_reg: data=%h busy=%b required 0 00", rd_data, rd_busy);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_init();
        wr_en   = 2'b01;
        wr_sel  = {5'd0, 5'd20};
        wr_data = {32'h0, 32'h12345678};
        step();
        idle_inputs();
        rd_sel = {5'd20, 5'd5};
        rst = 1'b1;
        step();
        if (ready !== 1'b0 || rd_data !== 64'h0) begin
            $display("FAIL run_reset_mask: ready=%b data=%h required 0 0", ready, rd_data);
            errors++;
        end
        checks++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) begin
                wr_en     = 2'b01;
                wr_sel    = {5'd0, 5'd2};
                wr_data   = {32'h0, 32'hABCD};
                claim_en  = 1'b1;
                claim_sel = 5'd2;
            end else begin
                idle_inputs();
            end
            #1;
            if (ready !== 1'b0) begin
                $display("FAIL restart_hold cycle %0d: ready=%b required 0", i, ready);
                errors++;
            end
            checks++;
            step();
        end
        idle_inputs();
        if (ready !== 1'b1) begin
            $display("FAIL restart_ready: ready=%b required 1", ready);
            errors++;
        end
        checks++;
        rd_sel = {5'd20, 5'd2};
        #1;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            $display("FAIL init_write_ignored: data=%h busy=%b required 0 00", rd_data, rd_busy);
            errors++;
        end
        checks++;
        rd_sel = {5'd9, 5'd5};
        #1;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            $display("FAIL reset_discard: data=%h busy=%b required 0 00", rd_data, rd_busy);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dual_write();
        test_back_to_back();
        test_scoreboard();
        test_zero_reg();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
